// File: rtl/hack_loader.sv
// Bootstrap loader: assembles a framed big-endian byte stream into 16-bit words,
// writes them to a RAM16K-style memory, then reads them back and checks the sum.
module hack_loader #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned BASE   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [15:0]       mem_in,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [15:0]       mem_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned LIMIT = (32'd1 << ADDR_W) - BASE;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_SUM, S_VERIFY, S_CHECK
  } state_t;

  state_t            r_state;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic [CNT_W-1:0]  r_len;
  logic [15:0]       r_cs;
  logic [15:0]       r_acc;
  logic [CNT_W-1:0]  r_idx;
  logic              r_rx_ready;
  logic [15:0]       r_mem_in;
  logic              r_mem_load;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [CNT_W-1:0]  r_count;

  logic              w_accept;
  logic              w_last_byte;
  logic [15:0]       w_word;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_idx_next;

  assign w_accept    = rx_valid & r_rx_ready;
  assign w_last_byte = w_accept & r_phase;
  assign w_word      = {r_hi, rx_data};
  assign w_cnt_next  = r_count + CNT_W'(1);
  assign w_idx_next  = r_idx + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_phase    <= 1'b0;
      r_hi       <= '0;
      r_len      <= '0;
      r_cs       <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_rx_ready <= 1'b0;
      r_mem_in   <= '0;
      r_mem_load <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_count    <= '0;
    end else begin
      // Phase 0 holds the high byte; phase 1 completes the word on the input bus.
      if (w_accept) begin
        r_phase <= ~r_phase;
        if (!r_phase) r_hi <= rx_data;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LEN;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_count    <= '0;
            r_phase    <= 1'b0;
            r_acc      <= '0;
            r_rx_ready <= 1'b1;
          end
        end
        S_LEN: begin
          if (w_last_byte) begin
            if (32'(w_word) > LIMIT) begin
              r_state    <= S_IDLE;
              r_error    <= 1'b1;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_rx_ready <= 1'b0;
            end else begin
              r_len   <= CNT_W'(w_word);
              r_state <= (w_word == 16'd0) ? S_SUM : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_last_byte) begin
            r_state    <= S_WRITE;
            r_rx_ready <= 1'b0;
            r_mem_load <= 1'b1;
            r_mem_addr <= BASE_A + ADDR_W'(r_count);
            r_mem_in   <= w_word;
          end
        end
        S_WRITE: begin
          r_mem_load <= 1'b0;
          r_count    <= w_cnt_next;
          r_rx_ready <= 1'b1;
          r_state    <= (w_cnt_next == r_len) ? S_SUM : S_DATA;
        end
        S_SUM: begin
          if (w_last_byte) begin
            r_cs       <= w_word;
            r_rx_ready <= 1'b0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_mem_addr <= BASE_A;
            r_state    <= S_VERIFY;
          end
        end
        S_VERIFY: begin
          // mem_out reflects the address registered on the previous edge.
          if (r_len != '0) r_acc <= r_acc + mem_out;
          if (r_len == '0 || w_idx_next == r_len) begin
            r_state <= S_CHECK;
          end else begin
            r_idx      <= w_idx_next;
            r_mem_addr <= BASE_A + ADDR_W'(w_idx_next);
          end
        end
        S_CHECK: begin
          r_error <= (r_acc != r_cs);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_ready    = r_rx_ready;
  assign mem_in      = r_mem_in;
  assign mem_load    = r_mem_load;
  assign mem_address = r_mem_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign count       = r_count;

endmodule
